// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle control unit for an RV32I datapath. Steps one instruction at a
//   time through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. It also supports a
//   debug halt, a sticky illegal-instruction trap and a retired-instruction
//   counter.
//
// Ports
//   clk            single clock, rising edge
//   reset          asynchronous active-low reset
//   opcode         instr[6:0]
//   funct3         instr[14:12]
//   funct7         instr[31:25]
//   mem_ready      data memory has completed the current access
//   debug_req      request a halt at the next instruction boundary
//   pc_write       PC load enable
//   alu_in_sel     1 = immediate, 0 = rs2_data
//   imm_sel        1 = S-type immediate, 0 = I-type immediate
//   alu_control    ALU operation code
//   mem_enable     data memory access strobe
//   mem_rd_wr_bar  1 = read, 0 = write
//   reg_write      register file write enable
//   reg_write_sel  1 = memory data, 0 = ALU result
//   debug_pc       routes the rs1 read port to the debug address
//   halted         unit is in HALT
//   illegal_instr  sticky illegal-instruction trap flag
//   retired_count  number of retired instructions (wraps)
module multicycle_control #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 mem_ready,
    input  logic                 debug_req,
    output logic                 pc_write,
    output logic                 alu_in_sel,
    output logic                 imm_sel,
    output logic [3:0]           alu_control,
    output logic                 mem_enable,
    output logic                 mem_rd_wr_bar,
    output logic                 reg_write,
    output logic                 reg_write_sel,
    output logic                 debug_pc,
    output logic                 halted,
    output logic                 illegal_instr,
    output logic [CNT_WIDTH-1:0] retired_count
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WRITEBACK,
        HALT,
        TRAP
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    state_t state;
    state_t next_state;

    logic       is_r;
    logic       is_i;
    logic       is_load;
    logic       is_store;
    logic [3:0] alu_op;

    // Instruction class. The opcode is stable from DECODE until pc_write,
    // so it can be decoded combinationally instead of being latched.
    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);

    always_comb begin
        alu_op = ALU_ADD;
        if (is_r || is_i) begin
            case (funct3)
                // Only R-type uses funct7[5] to select SUB. ADDI ignores it.
                3'b000:  alu_op = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Outputs are decoded from the state register, so they drop as soon as
    // reset asserts. The STORE completion pulse also depends on mem_ready.
    always_comb begin
        next_state    = state;
        pc_write      = 1'b0;
        alu_in_sel    = 1'b0;
        imm_sel       = 1'b0;
        alu_control   = ALU_ADD;
        mem_enable    = 1'b0;
        mem_rd_wr_bar = 1'b1;
        reg_write     = 1'b0;
        reg_write_sel = 1'b0;
        debug_pc      = 1'b0;
        halted        = 1'b0;
        illegal_instr = 1'b0;

        // The ALU setup chosen in EXECUTE is held through MEM and WRITEBACK.
        if (state == EXECUTE || state == MEM || state == WRITEBACK) begin
            alu_in_sel  = ~is_r;
            imm_sel     = is_store;
            alu_control = alu_op;
        end

        case (state)
            FETCH: begin
                next_state = debug_req ? HALT : DECODE;
            end
            DECODE: begin
                if (is_r || is_i || is_load || is_store) begin
                    next_state = EXECUTE;
                end else begin
                    next_state = TRAP;
                end
            end
            EXECUTE: begin
                next_state = (is_load || is_store) ? MEM : WRITEBACK;
            end
            MEM: begin
                mem_enable    = 1'b1;
                mem_rd_wr_bar = ~is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_write   = 1'b1;
                        next_state = FETCH;
                    end else begin
                        next_state = WRITEBACK;
                    end
                end
            end
            WRITEBACK: begin
                reg_write     = 1'b1;
                reg_write_sel = is_load;
                pc_write      = 1'b1;
                next_state    = FETCH;
            end
            HALT: begin
                debug_pc = 1'b1;
                halted   = 1'b1;
                if (!debug_req) begin
                    next_state = FETCH;
                end
            end
            TRAP: begin
                illegal_instr = 1'b1;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_count <= '0;
        end else if (pc_write) begin
            retired_count <= retired_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        mem_ready;
    logic        debug_req;
    logic        pc_write;
    logic        alu_in_sel;
    logic        imm_sel;
    logic [3:0]  alu_control;
    logic        mem_enable;
    logic        mem_rd_wr_bar;
    logic        reg_write;
    logic        reg_write_sel;
    logic        debug_pc;
    logic        halted;
    logic        illegal_instr;
    logic [31:0] retired_count;

    int unsigned n_total;
    int unsigned n_pass;

    multicycle_control #(.CNT_WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7        (funct7),
        .mem_ready     (mem_ready),
        .debug_req     (debug_req),
        .pc_write      (pc_write),
        .alu_in_sel    (alu_in_sel),
        .imm_sel       (imm_sel),
        .alu_control   (alu_control),
        .mem_enable    (mem_enable),
        .mem_rd_wr_bar (mem_rd_wr_bar),
        .reg_write     (reg_write),
        .reg_write_sel (reg_write_sel),
        .debug_pc      (debug_pc),
        .halted        (halted),
        .illegal_instr (illegal_instr),
        .retired_count (retired_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    // ALU decode vectors: opcode, funct3, funct7, expected alu_control, alu_in_sel.
    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] alu;
        logic       isel;
    } alu_vec_t;

    alu_vec_t vecs[6];

    initial begin
        n_total = 0;
        n_pass  = 0;

        vecs[0] = '{7'b0010011, 3'b101, 7'b0100000, 4'b0111, 1'b1}; // SRAI
        vecs[1] = '{7'b0010011, 3'b000, 7'b0100000, 4'b0000, 1'b1}; // ADDI, funct7[5] ignored
        vecs[2] = '{7'b0010011, 3'b101, 7'b0000000, 4'b0110, 1'b1}; // SRLI
        vecs[3] = '{7'b0110011, 3'b101, 7'b0100000, 4'b0111, 1'b0}; // SRA
        vecs[4] = '{7'b0110011, 3'b111, 7'b0000000, 4'b1001, 1'b0}; // AND
        vecs[5] = '{7'b0110011, 3'b011, 7'b0000000, 4'b0100, 1'b0}; // SLTU

        reset     = 1'b0;
        mem_ready = 1'b0;
        debug_req = 1'b0;
        set_instr(7'b0, 3'b0, 7'b0);

        // Reset state
        #12;
        check("rst_pc_write", pc_write, 0);
        check("rst_mem_enable", mem_enable, 0);
        check("rst_reg_write", reg_write, 0);
        check("rst_rdwr", mem_rd_wr_bar, 1);
        check("rst_alu", alu_control, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal_instr, 0);
        check("rst_debug_pc", debug_pc, 0);
        check("rst_count", retired_count, 0);
        reset = 1'b1;

        // R-type ADD (FETCH now)
        set_instr(7'b0110011, 3'b000, 7'b0000000);
        tick(); // DECODE
        check("add_dec_pcw", pc_write, 0);
        tick(); // EXECUTE
        check("add_alu", alu_control, 4'b0000);
        check("add_isel", alu_in_sel, 0);
        check("add_ex_regw", reg_write, 0);
        tick(); // WRITEBACK
        check("add_wb_regw", reg_write, 1);
        check("add_wb_sel", reg_write_sel, 0);
        check("add_wb_pcw", pc_write, 1);
        check("add_wb_alu", alu_control, 4'b0000);
        tick(); // FETCH
        check("add_fetch_pcw", pc_write, 0);
        check("add_count", retired_count, 1);

        // R-type SUB
        set_instr(7'b0110011, 3'b000, 7'b0100000);
        tick();
        tick();
        check("sub_alu", alu_control, 4'b0001);
        tick();
        check("sub_wb_pcw", pc_write, 1);
        tick();
        check("sub_count", retired_count, 2);

        // LOAD, mem_ready low for the first 3 MEM cycles
        set_instr(7'b0000011, 3'b010, 7'b0000000);
        mem_ready = 1'b0;
        tick(); // DECODE
        tick(); // EXECUTE
        check("ld_isel", alu_in_sel, 1);
        check("ld_imm_sel", imm_sel, 0);
        check("ld_alu", alu_control, 4'b0000);
        check("ld_ex_memen", mem_enable, 0);
        for (int i = 0; i < 4; i++) begin
            tick(); // MEM cycle i
            check("ld_mem_en", mem_enable, 1);
            check("ld_mem_rdwr", mem_rd_wr_bar, 1);
            check("ld_mem_pcw", pc_write, 0);
            check("ld_mem_regw", reg_write, 0);
            if (i == 3) begin
                mem_ready = 1'b1;
            end
        end
        tick(); // WRITEBACK
        check("ld_wb_regw", reg_write, 1);
        check("ld_wb_sel", reg_write_sel, 1);
        check("ld_wb_pcw", pc_write, 1);
        check("ld_wb_memen", mem_enable, 0);
        tick(); // FETCH
        check("ld_count", retired_count, 3);
        check("ld_fetch_pcw", pc_write, 0);

        // STORE, mem_ready already high (ignored outside MEM)
        set_instr(7'b0100011, 3'b010, 7'b0000000);
        tick(); // DECODE
        check("st_dec_memen", mem_enable, 0);
        tick(); // EXECUTE
        check("st_imm_sel", imm_sel, 1);
        check("st_isel", alu_in_sel, 1);
        check("st_ex_regw", reg_write, 0);
        check("st_ex_pcw", pc_write, 0);
        tick(); // MEM
        check("st_mem_en", mem_enable, 1);
        check("st_mem_rdwr", mem_rd_wr_bar, 0);
        check("st_mem_pcw", pc_write, 1);
        check("st_mem_regw", reg_write, 0);
        tick(); // FETCH after 4 cycles
        check("st_fetch_memen", mem_enable, 0);
        check("st_fetch_regw", reg_write, 0);
        check("st_count", retired_count, 4);
        mem_ready = 1'b0;

        // ALU decode table
        for (int v = 0; v < 6; v++) begin
            set_instr(vecs[v].op, vecs[v].f3, vecs[v].f7);
            tick();
            tick();
            check("vec_alu", alu_control, vecs[v].alu);
            check("vec_isel", alu_in_sel, vecs[v].isel);
            tick();
            check("vec_wb_pcw", pc_write, 1);
            tick();
            check("vec_count", retired_count, 5 + v);
        end

        // Debug request raised in EXECUTE of a LOAD
        set_instr(7'b0000011, 3'b010, 7'b0000000);
        mem_ready = 1'b1;
        tick(); // DECODE
        tick(); // EXECUTE
        debug_req = 1'b1;
        tick(); // MEM, completes at once
        check("dbg_mem_en", mem_enable, 1);
        check("dbg_halted_mem", halted, 0);
        tick(); // WRITEBACK
        check("dbg_wb_pcw", pc_write, 1);
        tick(); // FETCH
        check("dbg_count", retired_count, 11);
        check("dbg_fetch_halted", halted, 0);
        tick(); // HALT
        check("dbg_halted", halted, 1);
        check("dbg_debug_pc", debug_pc, 1);
        check("dbg_halt_pcw", pc_write, 0);
        tick(); // still HALT
        check("dbg_halted_hold", halted, 1);
        debug_req = 1'b0;
        tick(); // FETCH
        check("dbg_resume_halted", halted, 0);
        check("dbg_resume_dpc", debug_pc, 0);
        check("dbg_count_hold", retired_count, 11);

        // Reset pulsed in MEM of a LOAD
        mem_ready = 1'b0;
        tick(); // DECODE
        tick(); // EXECUTE
        tick(); // MEM
        check("rmem_en_before", mem_enable, 1);
        reset = 1'b0;
        #1;
        check("rmem_en_async", mem_enable, 0);
        check("rmem_count", retired_count, 0);
        #1;
        reset = 1'b1;

        // Illegal opcode -> TRAP
        set_instr(7'b1111111, 3'b000, 7'b0000000);
        tick(); // DECODE
        check("trap_dec_illegal", illegal_instr, 0);
        tick(); // TRAP
        check("trap_illegal", illegal_instr, 1);
        for (int c = 0; c < 100; c++) begin
            tick();
            check("trap_hold", illegal_instr, 1);
            check("trap_pcw", pc_write, 0);
        end
        check("trap_count", retired_count, 0);
        reset = 1'b0;
        #1;
        check("trap_rst_clear", illegal_instr, 0);
        #1;
        reset = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
